// File: rtl/jtdd2_vidout.sv
// Video output stage for jtdd2: colour expansion with blanking, programmable HS delay,
// and line/frame length measurement that flags stable timing for the scaler and OSD.
module jtdd2_vidout #(
    parameter int COLORW   = 4,
    parameter int HOFF_W   = 4,
    parameter int STABLE_N = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pxl_cen,
    input  logic [COLORW-1:0]   red,
    input  logic [COLORW-1:0]   green,
    input  logic [COLORW-1:0]   blue,
    input  logic                LHBL,
    input  logic                LVBL,
    input  logic                HS,
    input  logic                VS,
    input  logic [HOFF_W-1:0]   hs_offset,
    output logic [2*COLORW-1:0] out_r,
    output logic [2*COLORW-1:0] out_g,
    output logic [2*COLORW-1:0] out_b,
    output logic                out_hs,
    output logic                out_vs,
    output logic                out_de,
    output logic [9:0]          line_len,
    output logic [8:0]          frame_lines,
    output logic                timing_ok
);
    localparam int DEPTH = 2**HOFF_W;
    localparam int SW    = $clog2(STABLE_N + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_N);

    // S1 stage; hs_sr_q[0] doubles as the registered S1 HS and the head of the delay line.
    logic [COLORW-1:0] red_q, green_q, blue_q;
    logic              lhbl_q, lvbl_q, vs_q;
    logic [DEPTH-1:0]  hs_sr_q;
    logic              hs_prev_q, vs_prev_q;
    logic [HOFF_W-1:0] hs_off_q;

    logic [2*COLORW-1:0] out_r_q, out_g_q, out_b_q;
    logic                out_hs_q, out_vs_q, out_de_q;

    logic [9:0]    hcnt_q, hcnt_d, line_len_q, line_len_d;
    logic [8:0]    vcnt_q, vcnt_d, vcnt_next, frame_lines_q, frame_lines_d;
    logic          seen_hs_q, seen_hs_d, seen_vs_q, seen_vs_d;
    logic [18:0]   snap_q, snap_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic          hs_rise, vs_rise, active;

    assign hs_rise = hs_sr_q[0] & ~hs_prev_q;
    assign vs_rise = vs_q & ~vs_prev_q;
    assign active  = lhbl_q & lvbl_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        seen_hs_d     = seen_hs_q;
        seen_vs_d     = seen_vs_q;
        snap_d        = snap_q;
        stab_cnt_d    = stab_cnt_q;

        if (hcnt_q != 10'h3FF) hcnt_d = hcnt_q + 10'd1;
        vcnt_next = (hs_rise && vcnt_q != 9'h1FF) ? vcnt_q + 9'd1 : vcnt_q;
        vcnt_d    = vcnt_next;

        if (hs_rise) begin
            if (seen_hs_q) line_len_d = hcnt_q;
            hcnt_d    = 10'd1;
            seen_hs_d = 1'b1;
        end

        if (vs_rise) begin
            vcnt_d    = '0;
            seen_vs_d = 1'b1;
            if (seen_vs_q) begin
                // The snapshot uses this tick's line length so a short closing line is seen.
                frame_lines_d = vcnt_next;
                snap_d        = {line_len_d, vcnt_next};
                if (snap_d == snap_q) begin
                    if (stab_cnt_q != STAB_MAX) stab_cnt_d = stab_cnt_q + 1'b1;
                end else begin
                    stab_cnt_d = '0;
                end
            end
        end
    end

    // NOTE: the HS delay line is plain flops, so it is reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            lhbl_q        <= 1'b0;
            lvbl_q        <= 1'b0;
            vs_q          <= 1'b0;
            hs_sr_q       <= '0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            hs_off_q      <= '0;
            out_r_q       <= '0;
            out_g_q       <= '0;
            out_b_q       <= '0;
            out_hs_q      <= 1'b0;
            out_vs_q      <= 1'b0;
            out_de_q      <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            seen_hs_q     <= 1'b0;
            seen_vs_q     <= 1'b0;
            snap_q        <= '0;
            stab_cnt_q    <= '0;
        end else if (pxl_cen) begin
            red_q     <= red;
            green_q   <= green;
            blue_q    <= blue;
            lhbl_q    <= LHBL;
            lvbl_q    <= LVBL;
            vs_q      <= VS;
            hs_sr_q   <= {hs_sr_q[DEPTH-2:0], HS};
            hs_prev_q <= hs_sr_q[0];
            vs_prev_q <= vs_q;
            if (vs_rise) hs_off_q <= hs_offset;

            out_r_q  <= active ? {red_q, red_q}     : '0;
            out_g_q  <= active ? {green_q, green_q} : '0;
            out_b_q  <= active ? {blue_q, blue_q}   : '0;
            out_de_q <= active;
            out_vs_q <= vs_q;
            out_hs_q <= hs_sr_q[hs_off_q];

            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            seen_hs_q     <= seen_hs_d;
            seen_vs_q     <= seen_vs_d;
            snap_q        <= snap_d;
            stab_cnt_q    <= stab_cnt_d;
        end
    end

    assign out_r       = out_r_q;
    assign out_g       = out_g_q;
    assign out_b       = out_b_q;
    assign out_hs      = out_hs_q;
    assign out_vs      = out_vs_q;
    assign out_de      = out_de_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign timing_ok   = (stab_cnt_q == STAB_MAX);

endmodule

// File: tb/tb_jtdd2_vidout.sv
// Directed bench for jtdd2_vidout: colour/blanking pipeline, HS offset latching,
// line/frame measurement, stability flag, clock-enable hold and async reset.
module tb_jtdd2_vidout;
    logic       clk = 1'b0;
    logic       rst_n, pxl_cen;
    logic [3:0] red, green, blue, hs_offset;
    logic       LHBL, LVBL, HS, VS;
    logic [7:0] out_r, out_g, out_b;
    logic       out_hs, out_vs, out_de, timing_ok;
    logic [9:0] line_len;
    logic [8:0] frame_lines;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    jtdd2_vidout dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .red(red), .green(green), .blue(blue),
        .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS), .hs_offset(hs_offset),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
        .line_len(line_len), .frame_lines(frame_lines), .timing_ok(timing_ok)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel: a single enabled clock followed by an idle one.
    task automatic tick();
        pxl_cen = 1'b1;
        @(posedge clk); #1;
        pxl_cen = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic line(input int npx, input logic vs_lvl);
        for (int p = 0; p < npx; p++) begin
            HS = (p == 0);
            VS = vs_lvl;
            tick();
        end
        HS = 1'b0;
    endtask

    task automatic frame(input int npx, input int nl, input int last_px);
        line(npx, 1'b1);
        for (int l = 1; l < nl; l++) line((l == nl - 1) ? last_px : npx, 1'b0);
    endtask

    task automatic vs_pulse();
        VS = 1'b1;
        tick();
        check("vs_lat1", out_vs, 1'b0);
        tick();
        check("vs_lat2", out_vs, 1'b1);
        VS = 1'b0;
        tick();
        tick();
    endtask

    task automatic hs_latency(input string tag, input int exp);
        int n;
        HS = 1'b0;
        VS = 1'b0;
        repeat (20) tick();
        HS = 1'b1;
        tick();
        HS = 1'b0;
        n = 1;
        while (!out_hs && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, exp);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b0;
        red = 4'h0; green = 4'h0; blue = 4'h0;
        LHBL = 1'b1; LVBL = 1'b1; HS = 1'b0; VS = 1'b0; hs_offset = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_r", out_r, 8'h00);
        check("rst_de", out_de, 1'b0);
        check("rst_len", line_len, 10'd0);
        check("rst_ok", timing_ok, 1'b0);
        rst_n = 1'b1;

        // Line and frame measurement with 384-pixel lines, 5 lines per frame.
        line(384, 1'b1);
        check("first_line_len", line_len, 10'd0);
        line(384, 1'b0);
        check("line_len_384", line_len, 10'd384);
        check("de_active", out_de, 1'b1);
        for (int l = 2; l < 5; l++) line(384, 1'b0);
        check("frame_lines_f1", frame_lines, 9'd0);
        frame(384, 5, 384);
        check("frame_lines_5", frame_lines, 9'd5);
        check("ok_vs2", timing_ok, 1'b0);
        frame(384, 5, 384);
        check("ok_vs3", timing_ok, 1'b0);
        frame(384, 5, 384);
        check("ok_vs4", timing_ok, 1'b1);

        // Colour expansion and blanking.
        red = 4'hA; green = 4'h5; blue = 4'hF;
        tick();
        check("col_lat1", out_r, 8'h00);
        tick();
        check("col_r", out_r, 8'hAA);
        check("col_g", out_g, 8'h55);
        check("col_b", out_b, 8'hFF);
        check("col_de", out_de, 1'b1);
        LHBL = 1'b0;
        tick();
        check("hblank_lat1", out_r, 8'hAA);
        tick();
        check("hblank_r", out_r, 8'h00);
        check("hblank_g", out_g, 8'h00);
        check("hblank_b", out_b, 8'h00);
        check("hblank_de", out_de, 1'b0);
        LHBL = 1'b1; LVBL = 1'b0;
        tick();
        tick();
        check("vblank_r", out_r, 8'h00);
        check("vblank_de", out_de, 1'b0);
        LVBL = 1'b1;

        // HS offset only takes effect after a VS rise.
        hs_offset = 4'd5;
        hs_latency("hs_lat_mid", 2);
        vs_pulse();
        hs_latency("hs_lat_5", 7);
        hs_offset = 4'd15;
        vs_pulse();
        hs_latency("hs_lat_15", 17);

        // Stability: settle on 32x6, then one short closing line.
        red = 4'h3; green = 4'hC; blue = 4'h7;
        repeat (4) frame(32, 6, 32);
        check("stab_ok", timing_ok, 1'b1);
        check("stab_len", line_len, 10'd32);
        check("stab_lines", frame_lines, 9'd6);
        frame(32, 6, 31);
        line(32, 1'b1);
        check("short_len", line_len, 10'd31);
        check("short_drop", timing_ok, 1'b0);
        for (int l = 1; l < 6; l++) line(32, 1'b0);
        frame(32, 6, 32);
        check("recov_1", timing_ok, 1'b0);
        frame(32, 6, 32);
        check("recov_2", timing_ok, 1'b0);
        frame(32, 6, 32);
        check("recov_3", timing_ok, 1'b1);

        // Clock-enable hold: stop 17 pixels into a line, when the delayed HS is high.
        line(32, 1'b1);
        for (int p = 0; p < 17; p++) begin
            HS = (p == 0);
            VS = 1'b0;
            tick();
        end
        check("hold_pre_hs", out_hs, 1'b1);
        HS = 1'b1; VS = 1'b1; red = 4'h0; LHBL = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("hold_hs", out_hs, 1'b1);
        check("hold_r", out_r, 8'h33);
        check("hold_de", out_de, 1'b1);
        check("hold_vs", out_vs, 1'b0);
        check("hold_ok", timing_ok, 1'b1);
        HS = 1'b0; VS = 1'b0; red = 4'h3; LHBL = 1'b1;
        for (int p = 17; p < 32; p++) tick();
        line(32, 1'b0);
        check("hold_len", line_len, 10'd32);

        // Asynchronous reset mid-line.
        HS = 1'b1;
        tick();
        HS = 1'b0;
        repeat (5) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_r", out_r, 8'h00);
        check("arst_de", out_de, 1'b0);
        check("arst_len", line_len, 10'd0);
        check("arst_lines", frame_lines, 9'd0);
        check("arst_ok", timing_ok, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        line(32, 1'b1);
        check("post_rst_len0", line_len, 10'd0);
        line(32, 1'b0);
        check("post_rst_len", line_len, 10'd32);
        for (int l = 2; l < 6; l++) line(32, 1'b0);
        check("post_rst_lines0", frame_lines, 9'd0);
        line(32, 1'b1);
        check("post_rst_lines", frame_lines, 9'd6);

        // Saturation of both counters.
        line(1100, 1'b0);
        line(4, 1'b0);
        check("sat_line_len", line_len, 10'd1023);
        line(4, 1'b1);
        for (int l = 1; l < 520; l++) line(4, 1'b0);
        line(4, 1'b1);
        check("sat_frame_lines", frame_lines, 9'd511);
        check("sat_after_len", line_len, 10'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
